aes_sub_bytes_pipe: RTL and testbench

//  Multi-lane AES SubBytes/InvSubBytes engine for the round datapath and key expansion.

---
 rtl/aes_sub_bytes_pipe.sv | 160 ++++++++++++++++
 tb/tb_aes_sub_bytes_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes_pipe.sv
// AES SubBytes/InvSubBytes on LANES bytes; 2-cycle latency, one word per clock.
// Elastic 2-stage valid/ready pipe: in_ready = !s1_v | s2_adv, outputs held while out_ready is low.
module aes_sub_bytes_pipe #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               in_flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_inv,
  output logic               busy
);

  localparam int DW = 8 * LANES;

  // First listed entry sits at the top index, so the entry for byte b is at index ~b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0][7:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    if ((INV_EN != 0) && inv) return ISBOX[~b];
    return SBOX[~b];
  endfunction

  logic             s1_v_q, s1_v_d;
  logic [DW-1:0]    s1_data_q, s1_data_d;
  logic             s1_inv_q, s1_inv_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_v_q, s2_v_d;
  logic [DW-1:0]    s2_data_q, s2_data_d;
  logic             s2_inv_q, s2_inv_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic          s2_adv;
  logic          push;
  logic          s1_mv;
  logic [DW-1:0] lut_data;

  assign s2_adv   = !s2_v_q || out_ready;
  assign in_ready = !s1_v_q || s2_adv;
  assign push     = in_valid && in_ready && !in_flush;
  assign s1_mv    = s1_v_q && s2_adv && !in_flush;

  always_comb begin
    lut_data = '0;
    for (int i = 0; i < LANES; i++) begin
      lut_data[8*i +: 8] = sub_byte(s1_data_q[8*i +: 8], s1_inv_q);
    end
  end

  // Flush only clears valids; data registers simply stop loading.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_inv_d  = s1_inv_q;
    s1_tag_d  = s1_tag_q;
    if (s1_mv) s1_v_d = 1'b0;
    if (push) begin
      s1_v_d    = 1'b1;
      s1_data_d = in_data;
      s1_inv_d  = (INV_EN != 0) && in_inv;
      s1_tag_d  = in_tag;
    end
    if (in_flush) s1_v_d = 1'b0;
  end

  always_comb begin
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_inv_d  = s2_inv_q;
    s2_tag_d  = s2_tag_q;
    if (s2_adv) s2_v_d = s1_v_q;
    if (s1_mv) begin
      s2_data_d = lut_data;
      s2_inv_d  = s1_inv_q;
      s2_tag_d  = s1_tag_q;
    end
    if (in_flush) s2_v_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_inv_q  <= 1'b0;
      s1_tag_q  <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_inv_q  <= s1_inv_d;
      s1_tag_q  <= s1_tag_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_inv_q  <= 1'b0;
      s2_tag_q  <= '0;
    end else begin
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_inv_q  <= s2_inv_d;
      s2_tag_q  <= s2_tag_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
  assign out_inv   = s2_inv_q;
  assign busy      = s1_v_q || s2_v_q;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Bench for aes_sub_bytes_pipe: S-box model built from GF(2^8) arithmetic, queue scoreboard.
module tb_aes_sub_bytes_pipe;
  localparam int LANES = 4;
  localparam int TAG_W = 4;
  localparam int W     = 8 * LANES;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             in_valid  = 1'b0;
  logic [W-1:0]     in_data   = '0;
  logic             in_inv    = 1'b0;
  logic [TAG_W-1:0] in_tag    = '0;
  logic             in_flush  = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready, out_valid, out_inv, busy;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             f_in_ready, f_out_valid, f_out_inv, f_busy;
  logic [W-1:0]     f_out_data;
  logic [TAG_W-1:0] f_out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  typedef struct packed {
    logic [W-1:0]     data;
    logic [TAG_W-1:0] tag;
    logic             inv;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  aes_sub_bytes_pipe #(.LANES(LANES), .INV_EN(1), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag), .in_flush(in_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_inv(out_inv), .busy(busy)
  );

  aes_sub_bytes_pipe #(.LANES(LANES), .INV_EN(0), .TAG_W(TAG_W)) dut_f (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(f_in_ready),
    .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag), .in_flush(in_flush),
    .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data),
    .out_tag(f_out_tag), .out_inv(f_out_inv), .busy(f_busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b;
      logic [7:0] r;
      logic [7:0] s;
      b = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      end
      s = b;
      r = b;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      fwd_tab[x] = s ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
  endtask

  function automatic logic [W-1:0] sub_word(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int spur;
    #1 rst_n = 1'b0;
    in_valid = 1'b1; in_data = 32'h12345678; in_inv = 1'b0; in_tag = 4'h3;
    out_ready = 1'b1; in_flush = 1'b0;
    repeat (3) tick();
    look();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_checks++; if (out_tag !== 4'h0 || out_inv !== 1'b0) begin n_fail++; $display("FAIL reset_tag_inv got=%h/%b exp=0/0", out_tag, out_inv); end
    n_checks++; if (f_busy !== 1'b0 || f_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fwd_only got busy=%b rdy=%b exp 0/1", f_busy, f_in_ready); end
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    look();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    spur = 0;
    repeat (4) begin
      tick(); look();
      if (out_valid !== 1'b0 || busy !== 1'b0) spur++;
    end
    n_checks++; if (spur != 0) begin n_fail++; $display("FAIL reset_spurious got=%0d cycles exp=0", spur); end
  endtask

  task automatic test_forward();
    int lat;
    tick();
    in_valid = 1'b1; in_data = 32'h5301FF00; in_inv = 1'b0; in_tag = 4'hA; out_ready = 1'b1;
    look();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_accept got=%b exp=1", in_ready); end
    lat = 0;
    do begin tick(); in_valid = 1'b0; look(); lat++; end while (out_valid !== 1'b1 && lat < 10);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL fwd_latency got=%0d exp=2", lat); end
    n_checks++; if (out_data !== 32'hED7C1663) begin n_fail++; $display("FAIL fwd_data got=%h exp=ed7c1663", out_data); end
    n_checks++; if (out_tag !== 4'hA) begin n_fail++; $display("FAIL fwd_tag got=%h exp=a", out_tag); end
    n_checks++; if (out_inv !== 1'b0) begin n_fail++; $display("FAIL fwd_inv got=%b exp=0", out_inv); end
  endtask

  task automatic test_inverse();
    int lat;
    tick();
    in_valid = 1'b1; in_data = 32'hED7C1663; in_inv = 1'b1; in_tag = 4'h5; out_ready = 1'b1;
    look();
    lat = 0;
    do begin tick(); in_valid = 1'b0; look(); lat++; end while (out_valid !== 1'b1 && lat < 10);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL inv_latency got=%0d exp=2", lat); end
    n_checks++; if (out_data !== 32'h5301FF00) begin n_fail++; $display("FAIL inv_data got=%h exp=5301ff00", out_data); end
    n_checks++; if (out_inv !== 1'b1 || out_tag !== 4'h5) begin n_fail++; $display("FAIL inv_mode_tag got=%b/%h exp=1/5", out_inv, out_tag); end
    n_checks++; if (f_out_valid !== 1'b1 || f_out_data !== 32'h551047FB) begin n_fail++; $display("FAIL inv_disabled_data got v=%b d=%h exp v=1 d=551047fb", f_out_valid, f_out_data); end
    n_checks++; if (f_out_inv !== 1'b0 || f_out_tag !== 4'h5) begin n_fail++; $display("FAIL inv_disabled_mode got=%b/%h exp=0/5", f_out_inv, f_out_tag); end
  endtask

  task automatic test_sweep();
    logic [W-1:0] orig [64];
    logic [W-1:0] wd [64];
    logic         wi [64];
    exp_t e;
    int idx, got, cyc, stalls;
    for (int k = 0; k < 64; k++) orig[k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    for (int pass = 0; pass < 3; pass++) begin
      for (int k = 0; k < 64; k++) begin
        wd[k] = (pass == 1) ? sub_word(orig[k], 1'b0) : orig[k];
        wi[k] = (pass == 1) ? 1'b1 : ((pass == 2) ? k[0] : 1'b0);
      end
      idx = 0; got = 0; cyc = 0; stalls = 0;
      while (got < 64 && cyc < 90) begin
        tick();
        out_ready = 1'b1;
        in_valid = (idx < 64);
        if (idx < 64) begin in_data = wd[idx]; in_inv = wi[idx]; in_tag = 4'(idx) ^ 4'(pass); end
        look();
        cyc++;
        if (out_valid && out_ready) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++; $display("FAIL sweep%0d_unexpected got=%h", pass, out_data);
          end else begin
            e = sb.pop_front();
            got++;
            if (out_data !== e.data || out_tag !== e.tag || out_inv !== e.inv) begin
              n_fail++;
              $display("FAIL sweep%0d_word got=%h/%h/%b exp=%h/%h/%b", pass, out_data, out_tag, out_inv, e.data, e.tag, e.inv);
            end
          end
        end
        if (in_valid && in_ready) begin
          e.data = (pass == 1) ? orig[idx] : sub_word(wd[idx], wi[idx]);
          e.tag  = 4'(idx) ^ 4'(pass);
          e.inv  = wi[idx];
          sb.push_back(e);
          idx++;
        end else if (in_valid) begin
          stalls++;
        end
      end
      n_checks++; if (got != 64) begin n_fail++; $display("FAIL sweep%0d_count got=%0d exp=64", pass, got); end
      n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL sweep%0d_stalls got=%0d exp=0", pass, stalls); end
      n_checks++; if (cyc != 66) begin n_fail++; $display("FAIL sweep%0d_cycles got=%0d exp=66", pass, cyc); end
      sb.delete();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    localparam int N = 12;
    logic [W-1:0] wd [N];
    logic         wi [N];
    exp_t e;
    exp_t held;
    logic prev_stall;
    int idx, got, cyc;
    for (int k = 0; k < N; k++) begin wd[k] = $urandom; wi[k] = 1'($urandom_range(0, 1)); end
    idx = 0; got = 0; cyc = 0; prev_stall = 1'b0; held = '0;
    while (got < N && cyc < 300) begin
      tick();
      cyc++;
      out_ready = (cyc <= 5) ? 1'b0 : ((cyc == 6) ? 1'b1 : 1'($urandom_range(0, 1)));
      in_valid = (idx < N);
      if (idx < N) begin in_data = wd[idx]; in_inv = wi[idx]; in_tag = 4'(idx); end
      look();
      if (cyc == 5) begin
        n_checks++; if (idx != 2) begin n_fail++; $display("FAIL bp_held_count got=%0d exp=2", idx); end
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full got rdy=%b vld=%b exp 0/1", in_ready, out_valid); end
      end
      if (cyc == 6) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_passthrough got=%b exp=1", in_ready); end
      end
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || {out_data, out_tag, out_inv} !== held) begin
          n_fail++; $display("FAIL bp_stable got v=%b %h exp v=1 %h", out_valid, {out_data, out_tag, out_inv}, held);
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {out_data, out_tag, out_inv};
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL bp_unexpected got=%h", out_data);
        end else begin
          e = sb.pop_front();
          got++;
          if (out_data !== e.data || out_tag !== e.tag || out_inv !== e.inv) begin
            n_fail++; $display("FAIL bp_word got=%h/%h/%b exp=%h/%h/%b", out_data, out_tag, out_inv, e.data, e.tag, e.inv);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.data = sub_word(wd[idx], wi[idx]); e.tag = 4'(idx); e.inv = wi[idx];
        sb.push_back(e);
        idx++;
      end
    end
    n_checks++; if (got != N || sb.size() != 0) begin n_fail++; $display("FAIL bp_drain got=%0d left=%0d exp=%0d/0", got, sb.size(), N); end
    in_valid = 1'b0;
    sb.delete();
  endtask

  task automatic test_flush();
    logic [W-1:0] w0;
    int lat;
    w0 = 32'hA1B2C3D4;
    tick(); out_ready = 1'b0; in_valid = 1'b1; in_data = w0; in_inv = 1'b0; in_tag = 4'h1; look();
    tick(); in_data = 32'h0F1E2D3C; in_tag = 4'h2; look();
    tick(); in_data = 32'h99887766; in_tag = 4'h3; in_flush = 1'b1; look();
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre got vld=%b rdy=%b exp 1/0", out_valid, in_ready); end
    tick(); in_flush = 1'b0; in_valid = 1'b0; look();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_clear got vld=%b busy=%b exp 0/0", out_valid, busy); end
    n_checks++; if (out_data !== sub_word(w0, 1'b0)) begin n_fail++; $display("FAIL flush_data_kept got=%h exp=%h", out_data, sub_word(w0, 1'b0)); end
    tick(); out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11223344; in_tag = 4'h4; in_flush = 1'b1; look();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    tick(); in_flush = 1'b0; in_data = 32'hCAFEF00D; in_inv = 1'b1; in_tag = 4'h6; look();
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_drop got busy=%b rdy=%b exp 0/1", busy, in_ready); end
    lat = 0;
    do begin tick(); in_valid = 1'b0; look(); lat++; end while (out_valid !== 1'b1 && lat < 10);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL flush_next_latency got=%0d exp=2", lat); end
    n_checks++; if (out_data !== sub_word(32'hCAFEF00D, 1'b1) || out_tag !== 4'h6) begin n_fail++; $display("FAIL flush_next_word got=%h/%h exp=%h/6", out_data, out_tag, sub_word(32'hCAFEF00D, 1'b1)); end
  endtask

  task automatic test_reset_mid();
    int lat;
    tick(); out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h01020304; in_inv = 1'b0; in_tag = 4'h7; look();
    tick(); in_data = 32'h05060708; in_tag = 4'h8; look();
    tick(); in_data = 32'h090A0B0C; in_tag = 4'h9;
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got busy=%b vld=%b exp 1/1", busy, out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_valids got vld=%b busy=%b exp 0/0", out_valid, busy); end
    n_checks++; if (out_data !== 32'h0 || out_tag !== 4'h0) begin n_fail++; $display("FAIL rstmid_outputs got=%h/%h exp=0/0", out_data, out_tag); end
    in_valid = 1'b0;
    look();
    rst_n = 1'b1;
    tick(); in_valid = 1'b1; in_data = 32'h3C3D3E3F; in_inv = 1'b0; in_tag = 4'hB; look();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    lat = 0;
    do begin tick(); in_valid = 1'b0; look(); lat++; end while (out_valid !== 1'b1 && lat < 10);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL rstmid_latency got=%0d exp=2", lat); end
    n_checks++; if (out_data !== sub_word(32'h3C3D3E3F, 1'b0) || out_tag !== 4'hB) begin n_fail++; $display("FAIL rstmid_first_word got=%h/%h exp=%h/b", out_data, out_tag, sub_word(32'h3C3D3E3F, 1'b0)); end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_forward();
    test_inverse();
    test_sweep();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
